// File: rtl/disp_demux.sv
// ---------------------------------------------------------------------------
// DispDemux (module disp_demux)
//
// Receive side of a four-digit multiplexed seven-segment bus. The an/sseg
// lines are registered, each sample must stay unchanged for STABLE cycles
// before it is accepted, and accepted samples are decoded into four 8-bit
// digit registers. It also flags digit updates, completed frames, illegal
// enable patterns, and loss of scan activity.
//
// Parameters
//   STABLE    : cycles a sample must hold before commit (>= 2)
//   TIMEOUT_W : width of the activity watchdog counter
//
// Ports
//   clk       : sole clock, rising edge
//   reset_n   : asynchronous active-low reset
//   an[3:0]   : digit enables, active-low, synchronous to clk
//   sseg[7:0] : segment lines, synchronous to clk
//   out0..3   : last committed pattern for digit 0..3
//   upd[3:0]  : one-cycle pulse, bit k when outk is written
//   frame     : one-cycle pulse when all four digits have been seen
//   err       : one-cycle pulse on commit of an illegal an pattern
//   stale     : level, no legal commit for 2^TIMEOUT_W-1 cycles
// ---------------------------------------------------------------------------
module disp_demux #(
    parameter int STABLE    = 4,
    parameter int TIMEOUT_W = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [3:0] upd,
    output logic       frame,
    output logic       err,
    output logic       stale
);

    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

    typedef enum logic {
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [3:0]           s_an;
    logic [7:0]           s_seg;
    logic [CW-1:0]        cnt;
    logic [3:0]           seen;
    logic [3:0]           seen_next;
    logic [TIMEOUT_W-1:0] wd;
    logic [TIMEOUT_W-1:0] wd_next;
    logic                 changed;
    logic                 commit;
    logic [3:0]           sel;
    logic                 illegal;
    logic                 legal;

    // A raw sample differing from the registered one restarts the dwell.
    assign changed = ({an, sseg} != {s_an, s_seg});
    assign commit  = (state == ST_WAIT) && (cnt == CNT_MAX);

    // Decode the registered enable pattern into a one-hot digit select.
    // All-high is blanking and is neither a digit nor an error.
    always_comb begin
        sel     = 4'b0000;
        illegal = 1'b0;
        case (s_an)
            4'b1110: sel = 4'b0001;
            4'b1101: sel = 4'b0010;
            4'b1011: sel = 4'b0100;
            4'b0111: sel = 4'b1000;
            4'b1111: sel = 4'b0000;
            default: illegal = 1'b1;
        endcase
    end

    assign legal     = commit && (sel != 4'b0000);
    assign seen_next = seen | sel;

    // The watchdog saturates at all-ones; a legal commit restarts it.
    always_comb begin
        wd_next = wd;
        if (legal) begin
            wd_next = '0;
        end else if (wd != '1) begin
            wd_next = wd + TIMEOUT_W'(1);
        end
    end

    // Next state: a change always re-arms the dwell, even on the commit
    // edge, so the new value gets its own full dwell. Otherwise a commit
    // parks the FSM in HOLD so one dwell yields exactly one commit.
    always_comb begin
        next_state = state;
        if (changed) begin
            next_state = ST_WAIT;
        end else if (commit) begin
            next_state = ST_HOLD;
        end
    end

    // Input sampling register and dwell counter. The counter restarts at 1
    // because the edge that captures a new value is its first cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_an  <= 4'b1111;
            s_seg <= 8'hFF;
            cnt   <= '0;
        end else begin
            s_an  <= an;
            s_seg <= sseg;
            if (changed) begin
                cnt <= CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Watchdog and stale flag. Stale is derived from the next count so it
    // rises on the edge the counter reaches all-ones and falls on the same
    // edge as the legal commit that clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd    <= '0;
            stale <= 1'b0;
        end else begin
            wd    <= wd_next;
            stale <= &wd_next;
        end
    end

    // Commit side: digit registers, pulses and frame tracking. The commit
    // uses the registered sample, so a change arriving on the commit edge
    // does not disturb the value being written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out0  <= 8'h00;
            out1  <= 8'h00;
            out2  <= 8'h00;
            out3  <= 8'h00;
            upd   <= 4'b0000;
            frame <= 1'b0;
            err   <= 1'b0;
            seen  <= 4'b0000;
        end else begin
            upd   <= 4'b0000;
            frame <= 1'b0;
            err   <= 1'b0;
            if (legal) begin
                if (sel[0]) out0 <= s_seg;
                if (sel[1]) out1 <= s_seg;
                if (sel[2]) out2 <= s_seg;
                if (sel[3]) out3 <= s_seg;
                upd <= sel;
                if (seen_next == 4'b1111) begin
                    frame <= 1'b1;
                    seen  <= 4'b0000;
                end else begin
                    seen <= seen_next;
                end
            end else if (commit && illegal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_demux.sv
// ---------------------------------------------------------------------------
// tb_disp_demux
//
// Self-checking bench for disp_demux. Stimulus is a list of held an/sseg
// values; for each, a small reference model predicts the commit event
// (upd/frame/err plus written data) and queues it. A negedge monitor pops
// and compares every event the DUT emits. Direct checks cover reset, digit
// registers and the stale watchdog.
// ---------------------------------------------------------------------------
module tb_disp_demux;

    localparam int STABLE    = 4;
    localparam int TIMEOUT_W = 6;

    typedef struct packed {
        logic [3:0] upd;
        logic       frame;
        logic       err;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] an = 4'b1111;
    logic [7:0] sseg = 8'hFF;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] upd;
    logic       frame, err, stale;

    int         errors = 0;
    int         checks = 0;
    evt_t       exp_q[$];
    logic [11:0] last_in;
    int         run;
    logic [3:0] mdl_seen;
    evt_t       got_evt;
    evt_t       want_evt;

    disp_demux #(
        .STABLE   (STABLE),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .an     (an),
        .sseg   (sseg),
        .out0   (out0),
        .out1   (out1),
        .out2   (out2),
        .out3   (out3),
        .upd    (upd),
        .frame  (frame),
        .err    (err),
        .stale  (stale)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clears the reference model to its post-reset state.
    task automatic resetModel();
        exp_q.delete();
        last_in  = {4'b1111, 8'hFF};
        run      = 0;
        mdl_seen = 4'b0000;
    endtask

    // Predicts the event for a completed dwell of the given sample.
    task automatic pushExpected(input logic [3:0] an_v, input logic [7:0] seg_v);
        evt_t       e;
        logic [3:0] bitv;
        bitv = 4'b0000;
        e    = '0;
        case (an_v)
            4'b1110: bitv = 4'b0001;
            4'b1101: bitv = 4'b0010;
            4'b1011: bitv = 4'b0100;
            4'b0111: bitv = 4'b1000;
            default: bitv = 4'b0000;
        endcase
        if (bitv != 4'b0000) begin
            mdl_seen = mdl_seen | bitv;
            e.upd  = bitv;
            e.data = seg_v;
            if (mdl_seen == 4'b1111) begin
                e.frame  = 1'b1;
                mdl_seen = 4'b0000;
            end
            exp_q.push_back(e);
        end else if (an_v != 4'b1111) begin
            e.err = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Drives a value for n clock edges; a dwell completes on the STABLE-th
    // edge of an unchanged value, and its event appears one edge later.
    task automatic applyStimulus(input logic [3:0] an_v, input logic [7:0] seg_v,
                                 input int n);
        an   = an_v;
        sseg = seg_v;
        if ({an_v, seg_v} !== last_in) begin
            run     = 0;
            last_in = {an_v, seg_v};
        end
        repeat (n) begin
            @(posedge clk);
            #1;
            run++;
            if (run == STABLE) pushExpected(an_v, seg_v);
        end
    endtask

    // Event monitor: every pulse from the DUT must match the next
    // predicted event.
    always @(negedge clk) begin
        if (reset_n && (upd != 4'b0000 || frame || err)) begin
            got_evt.upd   = upd;
            got_evt.frame = frame;
            got_evt.err   = err;
            case (upd)
                4'b0001: got_evt.data = out0;
                4'b0010: got_evt.data = out1;
                4'b0100: got_evt.data = out2;
                4'b1000: got_evt.data = out3;
                default: got_evt.data = 8'h00;
            endcase
            checkOutput("upd_onehot", 32'($countones(upd) <= 1), 32'd1);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event", 32'(got_evt), 32'd0);
            end else begin
                want_evt = exp_q.pop_front();
                checkOutput("event", 32'(got_evt), 32'(want_evt));
            end
        end
    end

    initial begin
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_outs", {out3, out2, out1, out0}, 32'h0);
        checkOutput("rst_flags", 32'({upd, frame, err, stale}), 32'h0);
        reset_n = 1'b1;

        // Single digit held well past the dwell.
        applyStimulus(4'b1011, 8'hA4, 10);
        checkOutput("single_out2", 32'(out2), 32'hA4);

        // Two full scans; frame is predicted with the final digit.
        repeat (2) begin
            applyStimulus(4'b1110, 8'hC0, 8);
            applyStimulus(4'b1101, 8'hF9, 8);
            applyStimulus(4'b1011, 8'hA4, 8);
            applyStimulus(4'b0111, 8'hB0, 8);
        end
        checkOutput("scan_outs", {out3, out2, out1, out0}, 32'hB0A4F9C0);

        // Short dwell then an exact dwell ending on the commit edge.
        applyStimulus(4'b1101, 8'h5A, 3);
        applyStimulus(4'b1111, 8'hFF, 2);
        applyStimulus(4'b1101, 8'h5A, 4);
        applyStimulus(4'b1111, 8'hFF, 3);
        checkOutput("boundary_out1", 32'(out1), 32'h5A);

        // Glitch inside a slot: same digit commits twice.
        applyStimulus(4'b1110, 8'h92, 6);
        applyStimulus(4'b1110, 8'h93, 2);
        applyStimulus(4'b1110, 8'h92, 6);
        checkOutput("glitch_out0", 32'(out0), 32'h92);

        // Illegal enables, then blanking.
        applyStimulus(4'b0000, 8'h00, 6);
        applyStimulus(4'b1001, 8'h11, 5);
        applyStimulus(4'b1111, 8'hFF, 6);
        checkOutput("illegal_outs", {out3, out2, out1, out0}, 32'hB0A45A92);

        // Partial frame, then asynchronous reset mid-cycle.
        applyStimulus(4'b1101, 8'h11, 5);
        #6;
        checkOutput("queue_empty_pre_reset", 32'(exp_q.size()), 32'd0);
        an      = 4'b1111;
        sseg    = 8'hFF;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_outs", {out3, out2, out1, out0}, 32'h0);
        checkOutput("async_rst_flags", 32'({upd, frame, err, stale}), 32'h0);
        resetModel();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Watchdog: stale rises 63 cycles after release.
        applyStimulus(4'b1111, 8'hFF, 62);
        checkOutput("stale_before", 32'(stale), 32'd0);
        applyStimulus(4'b1111, 8'hFF, 1);
        checkOutput("stale_rise", 32'(stale), 32'd1);
        applyStimulus(4'b1110, 8'hC0, 4);
        checkOutput("stale_hold", 32'({upd, stale}), 32'h01);
        applyStimulus(4'b1110, 8'hC0, 1);
        checkOutput("stale_clear", 32'({upd, stale}), 32'h02);

        // Finish a frame begun before the watchdog commit; reset must have
        // discarded the earlier partial frame.
        applyStimulus(4'b1101, 8'hF9, 8);
        applyStimulus(4'b1011, 8'hA4, 8);
        applyStimulus(4'b0111, 8'hB0, 8);
        applyStimulus(4'b1111, 8'hFF, 6);
        checkOutput("post_reset_outs", {out3, out2, out1, out0}, 32'hB0A4F9C0);
        #6;
        checkOutput("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_demux.md
# disp_demux

Receive-side counterpart of the four-digit multiplexed seven-segment driver. It samples the time-multiplexed `an`/`sseg` bus, requires each digit slot to hold stable for a programmable dwell, and reconstructs the four 8-bit segment patterns into registers. It also reports per-digit updates, completed frames, illegal enable patterns and loss of scan activity. It sits on the same clock as the driver, in loopback/self-check logic or in a board-to-board display-bus monitor.

## Interface
- `STABLE`, 4: consecutive cycles an `an`/`sseg` sample must hold before commit; legal range ≥ 2.
- `TIMEOUT_W`, 20: width of the activity watchdog counter.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `an` in 4: digit enables, active-low, synchronous to `clk` (no synchronizer).
- `sseg` in 8: segment lines, synchronous to `clk`.
- `out0`..`out3` out 8 each: last committed pattern for digit 0..3.
- `upd` out 4: one-cycle pulse; bit k high for one cycle when `out`k is written.
- `frame` out 1: one-cycle pulse when all four digits have been committed since the last frame.
- `err` out 1: one-cycle pulse on commit of an illegal `an` pattern.
- `stale` out 1: level; high when no legal commit for 2^TIMEOUT_W−1 cycles.

## Operation
- Input register: `s_an`/`s_seg` capture `an`/`sseg` every cycle.
- Dwell counter `cnt`, width clog2(STABLE+1):
  - Loads 1 when raw {`an`,`sseg`} ≠ {`s_an`,`s_seg`}.
  - Otherwise increments, saturating at STABLE.
- FSM states:
  - WAIT: in WAIT with `cnt`==STABLE → commit, go to HOLD.
  - HOLD: any input change (`cnt` reload) → WAIT. Only one commit per dwell.
- Commit decode on `s_an`:
  - 1110/1101/1011/0111 select digit 0/1/2/3. Write `out`k ← `s_seg`, pulse `upd[k]`, set `seen[k]`, clear watchdog, clear `stale`.
  - 1111 (blanking) is ignored: no write, no `err`, `seen` unchanged; go to HOLD.
  - Any other pattern (0000, two or more low): pulse `err`, no write, `seen` unchanged.
- Frame tracking:
  - `seen_next` = `seen` | commit bit.
  - If `seen_next`==1111, pulse `frame` and load `seen` ← 0000 in the same cycle.
  - Repeated commits of the same digit do not advance the frame.
- Watchdog:
  - Increments every cycle, saturating at all-ones.
  - Cleared by a legal commit.
  - `stale` asserts the cycle the counter reaches all-ones. It stays high until the next legal commit and deasserts together with that commit's `upd`.

## Timing
- Reset (async assert, sync release by the surrounding design) forces:
  - `out0`..`out3`=8'h00; `upd`=0, `frame`=0, `err`=0, `stale`=0.
  - `seen`=0, `cnt`=0, FSM=WAIT, watchdog=0, `s_an`=4'b1111, `s_seg`=8'hFF.
- Reset mid-dwell discards the partial dwell. Reset mid-frame discards `seen`.
- Commit latency:
  - A value first sampled at edge E0 and held commits at edge E0+STABLE−1.
  - `out`k, `upd`, `frame` and `err` are registered and visible in the cycle following edge E0+STABLE.
  - A dwell of STABLE−1 cycles never commits.
- Input change on the commit edge: the commit still occurs with the old sample. `cnt` reloads to 1 for the new value.
- Glitch shorter than STABLE inside a slot: restarts the dwell, then re-commits the same digit.
  - Because of the intervening change, the digit produces a second `upd` pulse.
- `upd`, `frame` and `err` are never high for two consecutive cycles from one dwell. `upd` has at most one bit set.

## Test plan
- Reset behaviour: pulse `reset_n` low mid-simulation with clocks running.
  - All outputs read 0 immediately (asynchronous); `out*`=00.
  - The first commit after release needs a full STABLE dwell.
- Single digit, STABLE=4: hold `an`=1011, `sseg`=8'hA4 for 10 cycles.
  - Exactly one `upd`=0100 pulse; `out2`=A4.
  - No `frame`, no `err`.
- Full scan: cycle 1110/1101/1011/0111 with `sseg`=C0/F9/A4/B0, 8 cycles each.
  - `out0..3`=C0/F9/A4/B0.
  - `frame` pulses once, coincident with the digit-3 `upd`.
  - Repeating the scan gives one `frame` per scan.
- Short dwell and boundary: hold `an`=1101 for 3 cycles (STABLE=4), then 1111.
  - No commit.
  - Then hold 1101 for exactly 4 cycles: one commit.
- Illegal patterns: hold `an`=0000 for 6 cycles.
  - `err` pulses once; `out*` and `seen` unchanged.
  - Hold `an`=1111: no `err`, no `upd`.
- Watchdog, TIMEOUT_W=6: hold `an`=1111.
  - `stale` rises 63 cycles after reset release.
  - A valid 1110 dwell clears `stale` in the same cycle as `upd`=0001.
